// File: rtl/write_resp_router_pkg.sv
// Shared definitions for the write-response return path.
// Holds the AXI B response codes, the B-path FSM encoding and the master
// index width, which the write-address arbiter uses as well.
package write_resp_router_pkg;

  localparam int MASTERS_NUM    = 2;
  localparam int MASTER_ID_SIZE = $clog2(MASTERS_NUM);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [MASTER_ID_SIZE-1:0] master_id_t;

  // IDLE: waiting for a slave B beat; HOLD: presenting it to its master.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } b_state_e;

endpackage

// File: rtl/write_resp_router_resp_id_fifo.sv
// resp_id_fifo: synchronous FIFO of master indices, one entry per granted AW.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, data_i    enqueue request and payload
//   pop_i             dequeue request
//   full_o, empty_o   occupancy flags
//   count_o           current occupancy (holds the full value Depth)
//   head_o            oldest entry
// A push while full is honoured only when a pop happens in the same cycle;
// a pop while empty is ignored.
module resp_id_fifo #(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic [Width-1:0]         head_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/write_resp_router.sv
// write_resp_router: returns B responses from the shared slave port to the
// master whose AW was granted, in AW issue order.
// Ports:
//   ACLK, ARESET                        clock, synchronous active-high reset
//   AW_Grant_Valid/AW_Grant_Master      AW handshake completed, owning master
//   AW_Stall                            tracker full, arbiter must hold off
//   M_AXI_b*                            slave-side B channel
//   S00_AXI_b*, S01_AXI_b*              master-side B channels
//   Outstanding_Count                   AWs granted whose B is not yet delivered
//   Protocol_Error                      sticky: grant arrived with tracker full
module write_resp_router
  import write_resp_router_pkg::*;
#(
  parameter int Max_Outstanding = 4,
  parameter int Cnt_Width       = $clog2(Max_Outstanding) + 1
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      AW_Grant_Valid,
  input  logic [MASTER_ID_SIZE-1:0] AW_Grant_Master,
  output logic                      AW_Stall,
  input  logic                      M_AXI_bvalid,
  input  logic [1:0]                M_AXI_bresp,
  output logic                      M_AXI_bready,
  output logic                      S00_AXI_bvalid,
  output logic [1:0]                S00_AXI_bresp,
  input  logic                      S00_AXI_bready,
  output logic                      S01_AXI_bvalid,
  output logic [1:0]                S01_AXI_bresp,
  input  logic                      S01_AXI_bready,
  output logic [Cnt_Width-1:0]      Outstanding_Count,
  output logic                      Protocol_Error
);

  b_state_e                  state_q;
  master_id_t                tgt_q;
  logic [1:0]                resp_q;
  logic [MASTERS_NUM-1:0]    bvalid_q;
  logic                      err_q;

  logic                      fifo_full, fifo_empty, pop;
  master_id_t                fifo_head;
  logic [MASTERS_NUM-1:0]    s_bready;

  assign s_bready = {S01_AXI_bready, S00_AXI_bready};

  // Only the addressed master's ready retires the held response.
  assign pop = (state_q == ST_HOLD) && s_bready[tgt_q];

  resp_id_fifo #(
    .Width (MASTER_ID_SIZE),
    .Depth (Max_Outstanding)
  ) u_ids (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (AW_Grant_Valid),
    .data_i  (AW_Grant_Master),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (Outstanding_Count),
    .head_o  (fifo_head)
  );

  assign AW_Stall     = fifo_full;
  // Accept a slave beat only when we know who it belongs to.
  assign M_AXI_bready = (state_q == ST_IDLE) && !fifo_empty;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      tgt_q    <= '0;
      resp_q   <= RESP_OKAY;
      bvalid_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // A grant with the tracker full is lost unless a pop frees a slot.
      if (AW_Grant_Valid && fifo_full && !pop) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (M_AXI_bvalid && M_AXI_bready) begin
            resp_q   <= M_AXI_bresp;
            tgt_q    <= fifo_head;
            bvalid_q <= MASTERS_NUM'(1) << fifo_head;
            state_q  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (pop) begin
            bvalid_q <= '0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign S00_AXI_bvalid = bvalid_q[0];
  assign S01_AXI_bvalid = bvalid_q[1];
  assign S00_AXI_bresp  = bvalid_q[0] ? resp_q : RESP_OKAY;
  assign S01_AXI_bresp  = bvalid_q[1] ? resp_q : RESP_OKAY;
  assign Protocol_Error = err_q;

endmodule

// File: tb/tb_write_resp_router.sv
module tb_write_resp_router;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       AW_Grant_Valid;
  logic [0:0] AW_Grant_Master;
  logic       AW_Stall;
  logic       M_AXI_bvalid;
  logic [1:0] M_AXI_bresp;
  logic       M_AXI_bready;
  logic       S00_AXI_bvalid;
  logic [1:0] S00_AXI_bresp;
  logic       S00_AXI_bready;
  logic       S01_AXI_bvalid;
  logic [1:0] S01_AXI_bresp;
  logic       S01_AXI_bready;
  logic [2:0] Outstanding_Count;
  logic       Protocol_Error;

  write_resp_router dut (
    .ACLK              (ACLK),
    .ARESET            (ARESET),
    .AW_Grant_Valid    (AW_Grant_Valid),
    .AW_Grant_Master   (AW_Grant_Master),
    .AW_Stall          (AW_Stall),
    .M_AXI_bvalid      (M_AXI_bvalid),
    .M_AXI_bresp       (M_AXI_bresp),
    .M_AXI_bready      (M_AXI_bready),
    .S00_AXI_bvalid    (S00_AXI_bvalid),
    .S00_AXI_bresp     (S00_AXI_bresp),
    .S00_AXI_bready    (S00_AXI_bready),
    .S01_AXI_bvalid    (S01_AXI_bvalid),
    .S01_AXI_bresp     (S01_AXI_bresp),
    .S01_AXI_bready    (S01_AXI_bready),
    .Outstanding_Count (Outstanding_Count),
    .Protocol_Error    (Protocol_Error)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: queue of owners of outstanding writes, plus the beat
  // currently being offered to a master (if any).
  int unsigned q[$];
  bit          m_hold;
  int unsigned m_tgt;
  int unsigned m_resp;
  bit          m_err;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",   int'(Outstanding_Count), q.size());
    chk("stall",   int'(AW_Stall),          int'(q.size() == 4));
    chk("m_bready",int'(M_AXI_bready),      int'(!m_hold && q.size() > 0));
    chk("s0_valid",int'(S00_AXI_bvalid),    int'(m_hold && m_tgt == 0));
    chk("s1_valid",int'(S01_AXI_bvalid),    int'(m_hold && m_tgt == 1));
    chk("s0_resp", int'(S00_AXI_bresp),     (m_hold && m_tgt == 0) ? int'(m_resp) : 0);
    chk("s1_resp", int'(S01_AXI_bresp),     (m_hold && m_tgt == 1) ? int'(m_resp) : 0);
    chk("perr",    int'(Protocol_Error),    int'(m_err));
  endtask

  // One clock: drive inputs, check outputs against the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic step(input bit rst, input bit gv, input int gm, input bit mbv,
                      input int mresp, input bit b0, input bit b1);
    bit pop, full;
    ARESET          = rst;
    AW_Grant_Valid  = gv;
    AW_Grant_Master = 1'(gm);
    M_AXI_bvalid    = mbv;
    M_AXI_bresp     = 2'(mresp);
    S00_AXI_bready  = b0;
    S01_AXI_bready  = b1;
    #1;
    check_all();
    @(posedge ACLK);
    if (rst) begin
      q.delete();
      m_hold = 0; m_tgt = 0; m_resp = 0; m_err = 0;
    end else begin
      full = (q.size() == 4);
      pop  = m_hold && ((m_tgt == 0) ? b0 : b1);
      if (pop) begin
        void'(q.pop_front());
        m_hold = 0;
      end else if (!m_hold && q.size() > 0 && mbv) begin
        m_hold = 1; m_tgt = q[0]; m_resp = mresp;
      end
      if (gv) begin
        if (!full || pop) q.push_back(gm);
        else m_err = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_hold = 0; m_tgt = 0; m_resp = 0; m_err = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 3, 1, 1);
    idle(1);

    // Single write for M1, OKAY response.
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);   // M0 ready must not retire M1's beat
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Fill the tracker, then grant+pop together while full.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, i, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
    end
    idle(1);

    // Full tracker + grant with no pop -> sticky error.
    for (int i = 0; i < 4; i++) step(0, 1, i % 2, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Held SLVERR to M0 while M0 is not ready.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);

    // Slave B with empty tracker: never accepted.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3, 1, 1);

    // Reset while holding a response.
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 79) == 0,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 1),
           $urandom_range(0, 1),
           $urandom_range(0, 3),
           $urandom_range(0, 1),
           $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
